// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_access_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_W_DEFAULT    = 32;
  localparam int unsigned MEM_BYTES_DEFAULT = 128;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Latched request payload (address kept separately, its width is a parameter)
  typedef struct packed {
    logic              we;
    size_e             size;
    logic              is_unsigned;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Number of bytes touched by an access of the given size
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] mem_word,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] store_data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        ext_b;
  logic        ext_h;

  // Pick the addressed byte/half and its extension bit
  always_comb begin
    lane_b = mem_word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? mem_word[31:16] : mem_word[15:0];
    ext_b  = ~is_unsigned & lane_b[7];
    ext_h  = ~is_unsigned & lane_h[15];
  end

  // Load result: selected lane extended to a full word
  always_comb begin
    load_data_c = '0;
    case (size)
      SZ_BYTE: load_data_c = {{24{ext_b}}, lane_b};
      SZ_HALF: load_data_c = {{16{ext_h}}, lane_h};
      SZ_WORD: load_data_c = mem_word;
      default: load_data_c = '0;
    endcase
  end

  // Store result: current word with the addressed lane(s) replaced
  always_comb begin
    store_data_c = mem_word;
    case (size)
      SZ_BYTE: store_data_c[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) store_data_c[31:16] = wdata[15:0];
        else           store_data_c[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_data_c = wdata;
      default: store_data_c = mem_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_data_i
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              ready_q, ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  size_e             in_size;
  logic [EXT_W-1:0]  in_end;
  logic              in_err;
  logic [31:0]       in_addr_al;
  logic [31:0]       q_addr_al;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  // Legality check of the request currently offered on the input side
  always_comb begin
    in_size    = size_e'(req_size_i);
    in_end     = {1'b0, req_addr_i} + EXT_W'(size_bytes(in_size));
    in_err     = (in_size == SZ_RSVD)
               | ((in_size == SZ_HALF) & req_addr_i[0])
               | ((in_size == SZ_WORD) & (|req_addr_i[1:0]))
               | (in_end > EXT_W'(MEM_BYTES));
    in_addr_al = 32'({req_addr_i[ADDR_W-1:2], 2'b00});
    q_addr_al  = 32'({addr_q[ADDR_W-1:2], 2'b00});
  end

  mem_lane_align u_align (
    .mem_word     (mem_data_i),
    .offset       (addr_q[1:0]),
    .size         (req_q.size),
    .is_unsigned  (req_q.is_unsigned),
    .wdata        (req_q.wdata),
    .load_data_c  (load_data),
    .store_data_c (store_data)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    ready_d      = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_data_d   = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_d  = '{we: req_we_i, size: in_size, is_unsigned: req_unsigned_i,
                     wdata: req_wdata_i};
          addr_d = req_addr_i;
          if (in_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (req_we_i && in_size == SZ_WORD) begin
            state_d     = ST_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = in_addr_al;
            mem_data_d  = req_wdata_i;
          end else begin
            state_d    = ST_RD;
            mem_read_d = 1'b1;
            mem_addr_d = in_addr_al;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_RD: begin
        if (req_q.we) begin
          state_d     = ST_WR;
          mem_write_d = 1'b1;
          mem_addr_d  = q_addr_al;
          mem_data_d  = store_data;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latched request and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q        <= '0;
      addr_q       <= '0;
      ready_q      <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      req_q        <= req_d;
      addr_q       <= addr_d;
      ready_q      <= ready_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a response scoreboard and memory model.
module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  logic [31:0] mem [32];
  int          cyc = 0;
  int          vec_cnt = 0;
  int          miscmp = 0;
  string       cur_name = "reset";
  exp_t        sbq[$];
  ev_t         evq[$];
  exp_t        mon_e;
  ev_t         mon_ev;
  logic        saw_wr = 1'b0;
  vec_t        vt[23];

  mem_access_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Word-wide memory: combinational read, write commits on the rising edge
  assign mem_data_i = mem[mem_addr_o[6:2]];
  always @(posedge clk_i) if (mem_write_o) mem[mem_addr_o[6:2]] <= mem_data_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s/%s: got %h expected %h", cur_name, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [31:0] exp_wr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_wr = exp_wr;
    return v;
  endfunction

  // Monitor: memory activity log and response scoreboard
  always @(negedge clk_i) begin
    if (mem_read_o || mem_write_o) begin
      mon_ev.cyc = cyc; mon_ev.rd = mem_read_o; mon_ev.wr = mem_write_o;
      mon_ev.addr = mem_addr_o; mon_ev.data = mem_data_o;
      evq.push_back(mon_ev);
      if (mem_write_o) saw_wr = 1'b1;
    end
    if (mem_read_o && mem_write_o) chk("rd_wr_both", 32'(1), 32'(0));
    if (resp_valid_o) begin
      if (sbq.size() == 0) chk("unexpected_resp", 32'(1), 32'(0));
      else begin
        mon_e = sbq.pop_front();
        chk("rdata", resp_rdata_o, mon_e.rdata);
        chk("err", 32'(resp_err_o), 32'(mon_e.err));
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_ready();
    @(negedge clk_i);
    for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk_i);
    if (!req_ready_o) chk("ready_timeout", 32'(req_ready_o), 32'(1));
  endtask

  task automatic drive(input vec_t v);
    req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
    req_addr_i = v.addr; req_wdata_i = v.wdata; req_valid_i = 1'b1;
  endtask

  task automatic push_exp(input vec_t v, input int acc);
    exp_t e;
    int   lat;
    if (v.exp_err)            lat = 1;
    else if (!v.we)           lat = 2;
    else if (v.size == 2'b10) lat = 2;
    else                      lat = 3;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.cyc = acc + lat - 1;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sbq.size() != 0; i++) @(negedge clk_i);
    if (sbq.size() != 0) begin
      chk("resp_timeout", 32'(sbq.size()), 32'(0));
      sbq.delete();
    end
    #1;
  endtask

  // One request: drive, score the response, then check the memory activity it caused
  task automatic run_req(input vec_t v);
    int          acc;
    logic [31:0] wa;
    wait_ready();
    drive(v);
    evq.delete();
    @(posedge clk_i); #1;
    acc = cyc;
    req_valid_i = 1'b0;
    push_exp(v, acc);
    drain();
    wa = v.addr & ~32'h3;
    if (v.exp_err) begin
      chk("no_mem_access", 32'(evq.size()), 32'(0));
    end else if (!v.we || v.size == 2'b10) begin
      chk("ev_count", 32'(evq.size()), 32'(1));
      if (evq.size() >= 1) begin
        chk("ev0_off", 32'(evq[0].cyc - acc + 1), 32'(1));
        chk("ev0_rd", 32'(evq[0].rd), 32'(!v.we));
        chk("ev0_wr", 32'(evq[0].wr), 32'(v.we));
        chk("ev0_addr", evq[0].addr, wa);
        if (v.we) chk("ev0_data", evq[0].data, v.exp_wr);
      end
    end else begin
      chk("ev_count", 32'(evq.size()), 32'(2));
      if (evq.size() >= 2) begin
        chk("rmw_rd_off", 32'(evq[0].cyc - acc + 1), 32'(1));
        chk("rmw_rd", 32'(evq[0].rd), 32'(1));
        chk("rmw_rd_addr", evq[0].addr, wa);
        chk("rmw_wr_off", 32'(evq[1].cyc - acc + 1), 32'(2));
        chk("rmw_wr", 32'(evq[1].wr), 32'(1));
        chk("rmw_wr_addr", evq[1].addr, wa);
        chk("rmw_wr_data", evq[1].data, v.exp_wr);
      end
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    vec_t va;
    vec_t vb;

    for (int i = 0; i < 32; i++) mem[i] = '0;

    //          we    size   uns   addr    wdata          rdata          err   wr data
    vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'h00000000, 1'b0, 32'h8899AABB);
    vt[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 32'h0);
    vt[2]  = mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 32'h0);
    vt[3]  = mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000088, 1'b0, 32'h0);
    vt[4]  = mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 32'h0);
    vt[5]  = mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 32'h0);
    vt[6]  = mk(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h00000000, 1'b0, 32'h889955BB);
    vt[7]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h889955BB, 1'b0, 32'h0);
    vt[8]  = mk(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h00000000, 1'b1, 32'h0);
    vt[9]  = mk(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234,     32'h00000000, 1'b1, 32'h0);
    vt[10] = mk(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1, 32'h0);
    vt[11] = mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h00000000, 1'b1, 32'h0);
    vt[12] = mk(1'b0, 2'b10, 1'b0, 32'h7E, 32'h0,        32'h00000000, 1'b1, 32'h0);
    vt[13] = mk(1'b1, 2'b01, 1'b0, 32'h7E, 32'h1234F00D, 32'h00000000, 1'b0, 32'hF00D0000);
    vt[14] = mk(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0,        32'hFFFFFFF0, 1'b0, 32'h0);
    vt[15] = mk(1'b0, 2'b01, 1'b1, 32'h7E, 32'h0,        32'h0000F00D, 1'b0, 32'h0);
    vt[16] = mk(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        32'hF00D0000, 1'b0, 32'h0);
    vt[17] = mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 32'h00000000, 1'b0, 32'hCAFE55BB);
    vt[18] = mk(1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 32'h0);
    vt[19] = mk(1'b0, 2'b00, 1'b1, 32'h7F, 32'h0,        32'h000000F0, 1'b0, 32'h0);
    vt[20] = mk(1'b1, 2'b00, 1'b0, 32'h80, 32'h000000EE, 32'h00000000, 1'b1, 32'h0);
    vt[21] = mk(1'b1, 2'b00, 1'b0, 32'h7F, 32'h0000007A, 32'h00000000, 1'b0, 32'h7A0D0000);
    vt[22] = mk(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0,        32'h0000007A, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid_o), 32'(0));
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err", 32'(resp_err_o), 32'(0));
    chk("rst_mem_read", 32'(mem_read_o), 32'(0));
    chk("rst_mem_write", 32'(mem_write_o), 32'(0));
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cur_name = $sformatf("vec%0d", i);
      run_req(vt[i]);
    end

    // Response data holds while idle
    cur_name = "hold";
    repeat (3) @(negedge clk_i);
    chk("rdata_hold", resp_rdata_o, 32'h0000007A);
    chk("valid_low", 32'(resp_valid_o), 32'(0));

    // Reset while a sub-word store is in its read phase
    cur_name = "reset_mid_rmw";
    wait_ready();
    drive(mk(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 32'h0));
    saw_wr = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("in_rd", 32'(mem_read_o), 32'(1));
    chk("in_rd_addr", mem_addr_o, 32'h10);
    #1 rst_i = 1'b0;
    #1;
    chk("async_mem_read", 32'(mem_read_o), 32'(0));
    chk("async_mem_write", 32'(mem_write_o), 32'(0));
    chk("async_mem_addr", mem_addr_o, 32'h0);
    chk("async_mem_data", mem_data_o, 32'h0);
    chk("async_resp_valid", 32'(resp_valid_o), 32'(0));
    chk("async_rdata", resp_rdata_o, 32'h0);
    chk("async_ready", 32'(req_ready_o), 32'(1));
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("no_write_after_reset", 32'(saw_wr), 32'(0));
    chk("ready_after_reset", 32'(req_ready_o), 32'(1));
    chk("mem_unchanged", mem[4], 32'hCAFE55BB);
    cur_name = "lw_after_reset";
    run_req(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE55BB, 1'b0, 32'h0));

    // Valid held high across two back-to-back loads
    cur_name = "back_to_back";
    va = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE55BB, 1'b0, 32'h0);
    vb = mk(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'h7A0D0000, 1'b0, 32'h0);
    wait_ready();
    drive(va);
    @(posedge clk_i); #1;
    acc1 = cyc;
    push_exp(va, acc1);
    drive(vb);
    @(negedge clk_i);
    chk("ready_off1", 32'(req_ready_o), 32'(0));
    @(negedge clk_i);
    chk("ready_off2", 32'(req_ready_o), 32'(0));
    @(negedge clk_i);
    chk("ready_off3", 32'(req_ready_o), 32'(1));
    @(posedge clk_i); #1;
    acc2 = cyc;
    chk("second_accept", 32'(acc2 - acc1), 32'(3));
    push_exp(vb, acc2);
    req_valid_i = 1'b0;
    drain();
    repeat (3) @(negedge clk_i);
    chk("no_extra_resp", 32'(sbq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that drives the word-wide, byte-addressed data-memory port from the pipeline's MEM stage.
- Accepts one request at a time over a valid/ready handshake and supports byte, halfword and word sizes.
- Sub-word stores are done as read-modify-write, because the memory port writes whole 32-bit words only.
- Returns sign- or zero-extended load data, or an error flag, as a one-cycle response pulse.

Parameters:
- MEM_BYTES, 128, memory size in bytes; a request is legal only if req_addr_i + size_bytes <= MEM_BYTES.
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  2  00=byte, 01=half, 10=word, 11=reserved.
- req_unsigned_i  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned, out-of-range or reserved size.
- mem_addr_o  out  32  word-aligned address to memory.
- mem_data_o  out  32  write data to memory.
- mem_read_o  out  1  memory read enable.
- mem_write_o  out  1  memory write enable; memory commits on the rising edge.
- mem_data_i  in  32  combinational read data from memory, little-endian.

Behaviour:
- Reset: state returns to IDLE; every output is 0 except req_ready_o, which is 1; the latched request registers clear.
- States are IDLE, RD, WR, RESP. req_ready_o is 1 only in IDLE.
- IDLE: a request is accepted on a rising edge when req_valid_i and req_ready_o are both 1. The unit latches the request and checks it:
  - err if size=11;
  - err if half and addr[0]≠0;
  - err if word and addr[1:0]≠0;
  - err if the access is out of range.
  - On error go to RESP with err=1 and no memory access.
  - Otherwise: load → RD; word store → WR; byte/half store → RD.
- RD: mem_read_o=1, mem_addr_o=addr & ~3. mem_data_i is captured into the word register at the end of this cycle. Next state: load → RESP; sub-word store → WR.
- WR: mem_write_o=1, mem_addr_o=addr & ~3. mem_data_o is:
  - word store: req_wdata;
  - sub-word store: the captured word with the addressed lane(s) replaced. Byte lane = addr[1:0]; half lane = addr[1].
  - Next state → RESP.
- RESP: resp_valid_o=1 for exactly one cycle, then → IDLE. resp_rdata_o and resp_err_o keep their values until the next response.
- Latency, counted from the accept edge T:
  - error: response at T+1;
  - load: T+2;
  - word store: T+2;
  - sub-word store: T+3.
- Outside RD and WR, mem_read_o, mem_write_o, mem_addr_o and mem_data_o are all 0. mem_read_o and mem_write_o are never 1 in the same cycle.
- Load extraction: select the lane, then extend it to 32 bits with bit 7 (byte) or bit 15 (half), unless req_unsigned_i=1.
- Back-to-back requests: a new request is accepted no earlier than the first IDLE cycle after RESP.
- Inputs on the request side are ignored while the unit is busy.
- Reset mid-operation: the transaction aborts immediately. No partial write occurs, and no response is issued for the aborted request.

Decomposition:
- Package mem_access_pkg holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding ST_IDLE, ST_RD, ST_WR, ST_RESP;
  - the MEM_BYTES default.
- Sub-module mem_lane_align is purely combinational. It has two functions:
  - extract + extend, for loads;
  - lane merge, for stores.
- The FSM and the registers stay in mem_access_unit.

Test Plan:
- After reset, sw addr 0x10, data 0x8899AABB:
  - at T+1, mem_write_o=1, mem_addr_o=0x10, mem_data_o=0x8899AABB;
  - at T+2, resp_valid_o=1, err=0;
  - then lw 0x10 → mem_read_o=1 at T+1 and resp_rdata_o=0x8899AABB at T+2.
- Extraction, with 0x8899AABB at 0x10:
  - lb 0x13 → 0xFFFFFF88;
  - lbu 0x13 → 0x00000088;
  - lh 0x12 → 0xFFFF8899;
  - lhu 0x10 → 0x0000AABB.
- sb 0x11, data 0x00000055:
  - RD at T+1 with mem_addr_o=0x10;
  - WR at T+2 with mem_data_o=0x889955BB;
  - resp at T+3;
  - a following lw 0x10 returns 0x889955BB.
- Each of these requests gives resp_err_o=1 at T+1, with mem_read_o and mem_write_o never asserted:
  - lw 0x12;
  - sh 0x11;
  - size=11;
  - lw 0x80;
  - lw 0x7E.
- Reset during RD of a sub-word store:
  - outputs go to 0 asynchronously and mem_write_o is never asserted;
  - after release req_ready_o=1 and memory is unchanged.
- req_valid_i held high across two requests: the second is accepted on the first IDLE edge after the RESP cycle, and req_ready_o is low in between.
